// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for the LSU request interface. Serves one read or
// write at a time. Each request waits a fixed number of cycles, then the
// responder returns a single-cycle completion pulse.
//
// Handshake: the initiator raises read_en or write_en and holds it until it
// sees the matching *_success pulse. A request is captured only in IDLE. The
// FSM always returns through IDLE after the response, so a request that is
// still held in the RESP cycle is not captured a second time.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   write_en, read_en     request strobes (both high together = error request)
//   addr                  byte address (addr[1:0] ignored)
//   data_in, mask         write data and byte-lane strobes
//   w_success, r_success  one-cycle completion pulses
//   data_out              read data (holds the last read value)
//   busy                  transaction accepted and not yet complete
//   err                   error flag, pulses together with success
//   state_dbg             current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module dmem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            mask,
    output logic                  w_success,
    output logic                  r_success,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int                    IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH_WORDS * 4);
    localparam logic [3:0]            RD_LAT     = 4'(READ_LATENCY);
    localparam logic [3:0]            WR_LAT     = 4'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Request fields latched at capture time.
    logic                  op_rd_q, op_wr_q, op_err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            mask_q;

    logic                  capture;
    logic                  req_err;
    logic [3:0]            req_lat;
    logic                  enter_resp;

    // The "current" view of the request. When latency is 1, the edge that
    // captures the request is also the edge that enters RESP. At that edge
    // the latched copies do not exist yet, so the live inputs are used.
    logic                  cur_rd, cur_wr, cur_err;
    logic [IDX_W-1:0]      cur_idx;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [3:0]            cur_mask;

    assign capture = (state == S_IDLE) && (read_en || write_en);
    assign req_err = (read_en && write_en) || (addr >= ADDR_LIMIT);
    // A simultaneous read+write request completes after the write latency.
    assign req_lat = write_en ? WR_LAT : RD_LAT;

    always_comb begin
        cur_rd   = op_rd_q;
        cur_wr   = op_wr_q;
        cur_err  = op_err_q;
        cur_idx  = idx_q;
        cur_data = data_q;
        cur_mask = mask_q;
        if (capture) begin
            cur_rd   = read_en;
            cur_wr   = write_en;
            cur_err  = req_err;
            cur_idx  = addr[IDX_W+1:2];
            cur_data = data_in;
            cur_mask = mask;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (read_en || write_en) begin
                    if (req_lat <= 4'd1) begin
                        state_next = S_RESP;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = req_lat - 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = S_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign enter_resp = (state_next == S_RESP);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            r_success <= 1'b0;
            w_success <= 1'b0;
            err       <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            busy      <= (state_next != S_IDLE);
            r_success <= enter_resp && cur_rd;
            w_success <= enter_resp && cur_wr;
            err       <= enter_resp && cur_err;
            if (enter_resp && cur_rd) begin
                data_out <= cur_err ? '0 : mem[cur_idx];
            end
        end
    end

    // These fields are only read after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_rd_q  <= read_en;
            op_wr_q  <= write_en;
            op_err_q <= req_err;
            idx_q    <= addr[IDX_W+1:2];
            data_q   <= data_in;
            mask_q   <= mask;
        end
    end

    // The write commits on the edge that enters RESP. If reset is asserted
    // on that edge, the commit is suppressed. The array is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_wr && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_mask[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst_a, rst_b;
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] addr_i [2];
    logic [31:0] din_i  [2];
    logic [3:0]  mask_i [2];
    logic        r_succ [2];
    logic        w_succ [2];
    logic [31:0] dout   [2];
    logic        busy_o [2];
    logic        err_o  [2];
    logic [1:0]  st     [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] mdl [2][1024];

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default latencies: read 2, write 1.
    dmem_responder dut (
        .clk(clk), .rst(rst_a),
        .write_en(wr_i[0]), .read_en(rd_i[0]), .addr(addr_i[0]),
        .data_in(din_i[0]), .mask(mask_i[0]),
        .w_success(w_succ[0]), .r_success(r_succ[0]), .data_out(dout[0]),
        .busy(busy_o[0]), .err(err_o[0]), .state_dbg(st[0])
    );

    // Read latency 1 and write latency 3. This instance gives a write WAIT
    // window in which reset can be asserted.
    dmem_responder #(.READ_LATENCY(1), .WRITE_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .write_en(wr_i[1]), .read_en(rd_i[1]), .addr(addr_i[1]),
        .data_in(din_i[1]), .mask(mask_i[1]),
        .w_success(w_succ[1]), .r_success(r_succ[1]), .data_out(dout[1]),
        .busy(busy_o[1]), .err(err_o[1]), .state_dbg(st[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every read pulse pops the expected data for that instance.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_a && r_succ[0] === 1'b1) begin
            if (exp_q.size() == 0) check("rdata_unexpected_a", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("rdata_a", dout[0], e);
            end
        end
        if (!rst_b && r_succ[1] === 1'b1) begin
            if (exp_q_b.size() == 0) check("rdata_unexpected_b", 32'd1, 32'd0);
            else begin
                e = exp_q_b.pop_front();
                check("rdata_b", dout[1], e);
            end
        end
    end

    // Driver: issue one request, hold it until success, check latency/flags.
    task automatic do_req(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] dat,
                          input logic [3:0] m, input int exp_lat, input bit exp_err);
        int          cyc;
        bit          seen;
        logic [31:0] exp_rd;
        exp_rd = 32'd0;
        if (rd && !exp_err) exp_rd = mdl[d][a[11:2]];
        if (wr && !exp_err) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) mdl[d][a[11:2]][8*i +: 8] = dat[8*i +: 8];
        end
        if (rd) begin
            if (d == 0) exp_q.push_back(exp_rd);
            else exp_q_b.push_back(exp_rd);
        end
        @(negedge clk);
        rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; din_i[d] = dat; mask_i[d] = m;
        @(posedge clk);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (r_succ[d] || w_succ[d]) seen = 1;
            else check("busy_wait", 32'(busy_o[d]), 32'd1);
        end
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
        if (!seen) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("r_success", 32'(r_succ[d]), 32'(rd));
            check("w_success", 32'(w_succ[d]), 32'(wr));
            check("err", 32'(err_o[d]), 32'(exp_err));
            check("busy_resp", 32'(busy_o[d]), 32'd1);
        end
        @(negedge clk);
        check("succ_one_cycle", 32'(r_succ[d] | w_succ[d]), 32'd0);
        check("busy_after", 32'(busy_o[d]), 32'd0);
        check("err_after", 32'(err_o[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] words [4];
        int pulses, last, extra;
        for (int d = 0; d < 2; d++) begin
            rd_i[d] = 0; wr_i[d] = 0; addr_i[d] = 0; din_i[d] = 0; mask_i[d] = 0;
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_r_success", 32'(r_succ[0]), 32'd0);
        check("rst_w_success", 32'(w_succ[0]), 32'd0);
        check("rst_err", 32'(err_o[0]), 32'd0);
        check("rst_busy", 32'(busy_o[0]), 32'd0);
        check("rst_data_out", dout[0], 32'd0);
        check("rst_state", 32'(st[0]), 32'd0);

        do_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0);
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, 2, 0);
        repeat (2) @(negedge clk);
        check("data_out_hold", dout[0], 32'hDEADBEEF);

        do_req(0, 0, 1, 32'h10, 32'h11223344, 4'b0101, 1, 0);
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, 2, 0);
        check("mask_merge_model", mdl[0][4], 32'hDE22BE44);
        do_req(0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 0);

        do_req(0, 1, 0, 32'h1000, 32'h0, 4'hF, 2, 1);
        do_req(0, 0, 1, 32'h1000, 32'h55555555, 4'hF, 1, 1);
        do_req(0, 1, 1, 32'h10, 32'h0, 4'hF, 1, 1);
        do_req(0, 1, 0, 32'h10, 32'h0, 4'h0, 2, 0);
        do_req(0, 1, 0, 32'hFFC, 32'h0, 4'h0, 2, 0 == 1);

        for (int i = 0; i < 4; i++) begin
            words[i] = 10'($urandom_range(100, 1023));
            do_req(0, 0, 1, {20'd0, words[i], 2'b00}, $urandom, 4'hF, 1, 0);
        end
        for (int i = 0; i < 4; i++)
            do_req(0, 1, 0, {20'd0, words[i], 2'b01}, 32'h0, 4'h0, 2, 0);

        // Three reads with read_en held continuously.
        for (int i = 0; i < 3; i++) exp_q.push_back(mdl[0][4]);
        @(negedge clk);
        rd_i[0] = 1'b1; addr_i[0] = 32'h10; mask_i[0] = 4'h0;
        pulses = 0;
        last = 0;
        for (int c = 1; c <= 40 && pulses < 3; c++) begin
            @(negedge clk);
            if (r_succ[0]) begin
                pulses++;
                if (pulses == 1) check("hold_first", 32'(c), 32'd2);
                else check("hold_gap", 32'(c - last), 32'd3);
                last = c;
                if (pulses == 3) rd_i[0] = 1'b0;
            end
        end
        check("hold_count", 32'(pulses), 32'd3);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (r_succ[0]) extra++;
        end
        check("hold_extra", 32'(extra), 32'd0);

        // Second instance: latency-3 write, reset in WAIT, latency-1 read.
        do_req(1, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3, 0);
        @(negedge clk);
        wr_i[1] = 1'b1; addr_i[1] = 32'h20; din_i[1] = 32'h12345678; mask_i[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("b_busy_wait", 32'(busy_o[1]), 32'd1);
        check("b_state_wait", 32'(st[1]), 32'd1);
        rst_b = 1'b1;
        wr_i[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        check("b_busy_after_rst", 32'(busy_o[1]), 32'd0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (w_succ[1]) extra++;
        end
        check("b_no_w_success", 32'(extra), 32'd0);
        do_req(1, 1, 0, 32'h20, 32'h0, 4'h0, 1, 0);

        repeat (2) @(negedge clk);
        check("queue_a_empty", 32'(exp_q.size()), 32'd0);
        check("queue_b_empty", 32'(exp_q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
